// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty sequencer in front of the PWM generator: walks the PWM duty
// toward a requested target, one bounded step per PWM update handshake.
module duty_ramp_ctrl #(
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [R-1:0] target,
    input  logic         target_valid,
    output logic         target_ready,
    input  logic [R-1:0] step_size,
    input  logic         abort,
    output logic [R-1:0] pwm_duty,
    output logic         pwm_ready,
    input  logic         pwm_done,
    output logic [R-1:0] cur_duty,
    output logic         busy,
    output logic         ramp_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [R-1:0] tgt_q, tgt_d;
    logic [R-1:0] pwm_duty_q, pwm_duty_d;
    logic [R-1:0] cur_duty_q, cur_duty_d;
    logic         pwm_ready_q, pwm_ready_d;
    logic         ramp_done_q, ramp_done_d;

    // Step never overshoots: when the remaining distance fits in one step we land
    // exactly on the target, so cur +/- s cannot leave [0, 2^R-1].
    function automatic logic [R-1:0] next_step(input logic [R-1:0] cur,
                                               input logic [R-1:0] tg,
                                               input logic [R-1:0] ss);
        logic [R-1:0] s;
        logic [R:0]   diff;
        s = (ss == '0) ? {{(R-1){1'b0}}, 1'b1} : ss;
        if (tg >= cur) diff = {1'b0, tg} - {1'b0, cur};
        else           diff = {1'b0, cur} - {1'b0, tg};
        if (diff <= {1'b0, s}) return tg;
        else if (tg > cur)     return cur + s;
        else                   return cur - s;
    endfunction

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        pwm_duty_d  = pwm_duty_q;
        cur_duty_d  = cur_duty_q;
        pwm_ready_d = pwm_ready_q;
        ramp_done_d = 1'b0;

        if (abort) begin
            // The PWM has already loaded the offered duty if done coincides with abort.
            if (state_q == ST_REQ && pwm_done) cur_duty_d = pwm_duty_q;
            pwm_ready_d = 1'b0;
            state_d     = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (target_valid) begin
                tgt_d = target;
                if (target == cur_duty_q) begin
                    ramp_done_d = 1'b1;
                end else begin
                    pwm_duty_d  = next_step(cur_duty_q, target, step_size);
                    pwm_ready_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
        end else if (pwm_done) begin
            cur_duty_d = pwm_duty_q;
            if (pwm_duty_q == tgt_q) begin
                pwm_ready_d = 1'b0;
                ramp_done_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                pwm_duty_d = next_step(pwm_duty_q, tgt_q, step_size);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            pwm_duty_q  <= '0;
            cur_duty_q  <= '0;
            pwm_ready_q <= 1'b0;
            ramp_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            pwm_duty_q  <= pwm_duty_d;
            cur_duty_q  <= cur_duty_d;
            pwm_ready_q <= pwm_ready_d;
            ramp_done_q <= ramp_done_d;
        end
    end

    assign target_ready = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_REQ);
    assign pwm_duty     = pwm_duty_q;
    assign pwm_ready    = pwm_ready_q;
    assign cur_duty     = cur_duty_q;
    assign ramp_done    = ramp_done_q;

endmodule

// File: doc/duty_ramp_ctrl.md
# duty_ramp_ctrl

Soft-start / slew-limited duty sequencer that sits directly upstream of the PWM generator. It accepts a target duty over a valid/ready handshake and walks the PWM duty toward it in bounded steps, at most one step per PWM period. Each step is offered to the PWM through its `ready`/`done` update handshake, so duty changes only at period boundaries. It also reports when the ramp completes.

## Interface
- `R`, 8, duty width; must match the PWM generator's `R`.
- `clk`  in  1  system clock, same domain as the PWM generator.
- `reset_n`  in  1  asynchronous, active-low reset.
- `target`  in  R  requested final duty.
- `target_valid`  in  1  `target` is valid this cycle.
- `target_ready`  out  1  block accepts a new target; combinational, high only in `IDLE`.
- `step_size`  in  R  maximum duty change per PWM period; 0 is treated as 1; sampled on every step computation.
- `abort`  in  1  stop the ramp and keep the last committed duty.
- `pwm_duty`  out  R  duty offered to the PWM; registered.
- `pwm_ready`  out  1  update pending; drives the PWM `ready` input; registered.
- `pwm_done`  in  1  1-cycle pulse from the PWM: the offered duty has been loaded.
- `cur_duty`  out  R  duty currently in effect in the PWM; registered.
- `busy`  out  1  a ramp is in progress (state `REQ`).
- `ramp_done`  out  1  1-cycle pulse when `cur_duty` reaches the target.

## Operation
- States: `IDLE` and `REQ`.
- **IDLE, no accept:** `pwm_ready`=0 and `target_ready`=1.
- **IDLE, accept** (`target_valid`=1 in `IDLE`):
  - Latch the target into `tgt`.
  - If `tgt` == `cur_duty`: stay in `IDLE` and pulse `ramp_done` next cycle; no PWM request is made.
  - Otherwise: compute the next step, load `pwm_duty`, set `pwm_ready`=1, go to `REQ`.
- **Step arithmetic:**
  - `s` = max(`step_size`, 1).
  - `diff` = |`tgt` − `cur_duty`|, computed at R+1 bits.
  - If `diff` ≤ `s`: next = `tgt`. Otherwise next = `cur_duty` ± `s`, with the sign toward `tgt`.
  - Never overshoots, never wraps. The result is always within [0, 2^R−1].
- **REQ:**
  - `pwm_duty` and `pwm_ready` are held stable until `pwm_done`.
  - On `pwm_done`: `cur_duty` ← `pwm_duty`.
  - If `pwm_duty` == `tgt`: clear `pwm_ready`, pulse `ramp_done`, go to `IDLE`.
  - Otherwise: compute the next step from the new `cur_duty` in the same cycle, load `pwm_duty`, keep `pwm_ready`=1.
- **abort** (any state; priority over `pwm_done` and accept):
  - Clear `pwm_ready`, go to `IDLE`. `cur_duty` is unchanged, no `ramp_done`.
  - Exception: if `pwm_done` is asserted in the same cycle, `cur_duty` still takes `pwm_duty`, because the PWM has already loaded it.
- **Stray input:** `pwm_done` while `pwm_ready`=0 is ignored.
- **Target stability:** `target` is not re-sampled during `REQ`. Changing the target mid-ramp requires `abort`, then a new accept.

## Timing
- **Reset values:** `pwm_duty`=0, `cur_duty`=0, `pwm_ready`=0, `ramp_done`=0, `busy`=0, state `IDLE` (so `target_ready`=1 in reset).
- **Accept latency:** accept at edge k gives `pwm_ready`=1 and a valid `pwm_duty` after edge k.
- **done latency:** `pwm_done` sampled at edge k gives an updated `cur_duty` after edge k. The next `pwm_duty` or the `ramp_done` pulse also appears after edge k.
- **Handshake rules:** `pwm_ready` is never deasserted before `pwm_done`, except on `abort`. At most one step per PWM period, because the PWM loads at its counter wrap.
- **Ramp duration:** ceil(|target − start| / s) PWM periods.
- **ramp_done:** exactly 1 cycle wide. It is never asserted together with `pwm_ready` rising for a new ramp; the earliest new accept is the cycle after `ramp_done`.
- **Reset mid-ramp:** all outputs return to reset values immediately, asynchronously.

## Test plan
- **Up-ramp:** reset, then target=100, step_size=30, bench returns `pwm_done` 5 cycles after each `pwm_ready` rise → `pwm_duty` sequence 30, 60, 90, 100; `cur_duty` ends at 100; one `ramp_done` pulse; `pwm_ready` low afterward.
- **Down-ramp with exact landing:** from `cur_duty`=100, target=40, step_size=20 → 80, 60, 40; no value below 40 ever offered.
- **Zero step and full scale:** step_size=0, target=3 from 0 → 1, 2, 3. Then target=255 with step_size=200 → 203, 255; no wrap at 8 bits.
- **Equal target:** `cur_duty`=50, target=50 → `ramp_done` the next cycle; `pwm_ready` never asserts.
- **Abort mid-ramp:** abort during the second step of 0→100 with step 30 (`pwm_duty`=60 pending, no done) → `pwm_ready` drops, `cur_duty`=30, no `ramp_done`, `target_ready`=1. Repeat with `abort` and `pwm_done` in the same cycle → `cur_duty`=60.
- **Async reset mid-ramp:** assert `reset_n`=0 between clock edges during a ramp → all outputs go to 0 immediately. Also drive stray `pwm_done` pulses in `IDLE` → no state change.
